alu_regfile_datapath: RTL and testbench

- Single-cycle 64-bit datapath: a 32 x 64-bit register file, a B-operand mux (register or constant K), a 5-bit-function ALU, and a shared data bus driven by tri-state-style enables.
- The bus value is written back to the register file on the rising clock edge.
- The low 16 bits of every register are exported as debug taps for bench observation.
- Sits under the control unit. All control (FS, addresses, enables) comes from outside.

---
 rtl/alu_regfile_datapath.sv | 143 ++++++++++++++
 tb/tb_alu_regfile_datapath.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_regfile_datapath.sv
// 64-bit single-cycle datapath: 32 x 64 register file (r31 hard-wired to zero),
// B-operand mux, 5-bit-function ALU and a shared write-back bus.
// The low 16 bits of every register are exported as debug taps r0..r31.
module alu_regfile_datapath (
  input  logic        clock,
  input  logic        reset,
  input  logic        cin,
  input  logic        Bselect,
  input  logic        write,
  input  logic        EN_B,
  input  logic        EN_ALU,
  input  logic [4:0]  FS,
  input  logic [63:0] K,
  input  logic [4:0]  AA,
  input  logic [4:0]  BA,
  input  logic [4:0]  DA,
  output logic [15:0] r0,
  output logic [15:0] r1,
  output logic [15:0] r2,
  output logic [15:0] r3,
  output logic [15:0] r4,
  output logic [15:0] r5,
  output logic [15:0] r6,
  output logic [15:0] r7,
  output logic [15:0] r8,
  output logic [15:0] r9,
  output logic [15:0] r10,
  output logic [15:0] r11,
  output logic [15:0] r12,
  output logic [15:0] r13,
  output logic [15:0] r14,
  output logic [15:0] r15,
  output logic [15:0] r16,
  output logic [15:0] r17,
  output logic [15:0] r18,
  output logic [15:0] r19,
  output logic [15:0] r20,
  output logic [15:0] r21,
  output logic [15:0] r22,
  output logic [15:0] r23,
  output logic [15:0] r24,
  output logic [15:0] r25,
  output logic [15:0] r26,
  output logic [15:0] r27,
  output logic [15:0] r28,
  output logic [15:0] r29,
  output logic [15:0] r30,
  output logic [15:0] r31
);

  // Current contents of every register; entry 31 is a constant zero.
  logic [63:0] rf_q [0:31];
  logic [63:0] bus_next;

  // Registers are individual flops so that reads stay fully combinational
  // (no bypass: a same-cycle read of DA sees the pre-edge value).
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi < 31) begin : g_store
        logic [63:0] data_reg;
        // Clear on reset (priority over write), otherwise capture the bus when addressed.
        always_ff @(posedge clock) begin
          if (!reset)
            data_reg <= '0;
          else if (write && (DA == gi[4:0]))
            data_reg <= bus_next;
        end
        assign rf_q[gi] = data_reg;
      end else begin : g_zero
        assign rf_q[gi] = '0;
      end
    end
  endgenerate

  logic [63:0] a_op;
  logic [63:0] b_op;
  logic [63:0] a_pre;
  logic [63:0] b_pre;
  logic [63:0] alu_result;

  assign a_op  = rf_q[AA];
  assign b_op  = Bselect ? K : rf_q[BA];
  assign a_pre = FS[0] ? ~a_op : a_op;
  assign b_pre = FS[1] ? ~b_op : b_op;

  // ALU operation select; shifts use the raw operands and ignore FS[1:0].
  always_comb begin
    alu_result = '0;
    case (FS[4:2])
      3'b000:  alu_result = a_pre & b_pre;
      3'b001:  alu_result = a_pre | b_pre;
      3'b010:  alu_result = a_pre + b_pre + {63'd0, cin};
      3'b011:  alu_result = a_pre ^ b_pre;
      3'b100:  alu_result = a_op << b_op[5:0];
      3'b101:  alu_result = a_op >> b_op[5:0];
      default: alu_result = '0;
    endcase
  end

  // Bus source: ALU wins over the B operand; an undriven bus reads as zero.
  always_comb begin
    bus_next = '0;
    if (EN_ALU)
      bus_next = alu_result;
    else if (EN_B)
      bus_next = b_op;
  end

  assign r0  = rf_q[0][15:0];
  assign r1  = rf_q[1][15:0];
  assign r2  = rf_q[2][15:0];
  assign r3  = rf_q[3][15:0];
  assign r4  = rf_q[4][15:0];
  assign r5  = rf_q[5][15:0];
  assign r6  = rf_q[6][15:0];
  assign r7  = rf_q[7][15:0];
  assign r8  = rf_q[8][15:0];
  assign r9  = rf_q[9][15:0];
  assign r10 = rf_q[10][15:0];
  assign r11 = rf_q[11][15:0];
  assign r12 = rf_q[12][15:0];
  assign r13 = rf_q[13][15:0];
  assign r14 = rf_q[14][15:0];
  assign r15 = rf_q[15][15:0];
  assign r16 = rf_q[16][15:0];
  assign r17 = rf_q[17][15:0];
  assign r18 = rf_q[18][15:0];
  assign r19 = rf_q[19][15:0];
  assign r20 = rf_q[20][15:0];
  assign r21 = rf_q[21][15:0];
  assign r22 = rf_q[22][15:0];
  assign r23 = rf_q[23][15:0];
  assign r24 = rf_q[24][15:0];
  assign r25 = rf_q[25][15:0];
  assign r26 = rf_q[26][15:0];
  assign r27 = rf_q[27][15:0];
  assign r28 = rf_q[28][15:0];
  assign r29 = rf_q[29][15:0];
  assign r30 = rf_q[30][15:0];
  assign r31 = rf_q[31][15:0];

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Bench for alu_regfile_datapath: directed vector table, reset corner cases,
// then randomized cycles checked against a register-array reference model.
module tb_alu_regfile_datapath;

  logic        clock = 1'b0;
  logic        reset;
  logic        cin, Bselect, write, EN_B, EN_ALU;
  logic [4:0]  FS, AA, BA, DA;
  logic [63:0] K;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14, r15;
  logic [15:0] r16, r17, r18, r19, r20, r21, r22, r23, r24, r25, r26, r27, r28, r29, r30, r31;
  logic [15:0] tap [32];

  int checks = 0;
  int errors = 0;

  logic [63:0] mdl [32];

  typedef struct {
    logic        cin, bsel, wr, en_b, en_alu;
    logic [4:0]  fs, aa, ba, da;
    logic [63:0] k;
    int          chk;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[$];

  always #5 clock = ~clock;

  alu_regfile_datapath dut (
    .clock(clock), .reset(reset), .cin(cin), .Bselect(Bselect), .write(write),
    .EN_B(EN_B), .EN_ALU(EN_ALU), .FS(FS), .K(K), .AA(AA), .BA(BA), .DA(DA),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14), .r15(r15),
    .r16(r16), .r17(r17), .r18(r18), .r19(r19), .r20(r20), .r21(r21), .r22(r22), .r23(r23),
    .r24(r24), .r25(r25), .r26(r26), .r27(r27), .r28(r28), .r29(r29), .r30(r30), .r31(r31)
  );

  assign tap[0] = r0;   assign tap[1] = r1;   assign tap[2] = r2;   assign tap[3] = r3;
  assign tap[4] = r4;   assign tap[5] = r5;   assign tap[6] = r6;   assign tap[7] = r7;
  assign tap[8] = r8;   assign tap[9] = r9;   assign tap[10] = r10; assign tap[11] = r11;
  assign tap[12] = r12; assign tap[13] = r13; assign tap[14] = r14; assign tap[15] = r15;
  assign tap[16] = r16; assign tap[17] = r17; assign tap[18] = r18; assign tap[19] = r19;
  assign tap[20] = r20; assign tap[21] = r21; assign tap[22] = r22; assign tap[23] = r23;
  assign tap[24] = r24; assign tap[25] = r25; assign tap[26] = r26; assign tap[27] = r27;
  assign tap[28] = r28; assign tap[29] = r29; assign tap[30] = r30; assign tap[31] = r31;

  // Reference: value placed on the bus, derived from the operation rules directly.
  function automatic logic [63:0] ref_bus();
    logic [63:0] a, b, ai, bi;
    logic [63:0] res;
    a  = mdl[AA];
    b  = Bselect ? K : mdl[BA];
    ai = FS[0] ? (64'hFFFF_FFFF_FFFF_FFFF - a) : a;
    bi = FS[1] ? (64'hFFFF_FFFF_FFFF_FFFF - b) : b;
    case (FS[4:2])
      3'd0: res = ai & bi;
      3'd1: res = ai | bi;
      3'd2: res = ai + bi + 64'(cin);
      3'd3: res = ai ^ bi;
      3'd4: res = a * (64'd1 << b[5:0]);
      3'd5: res = a / (64'd1 << b[5:0]);
      default: res = 64'd0;
    endcase
    if (EN_ALU)    return res;
    else if (EN_B) return b;
    else           return 64'd0;
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (tap[i] !== mdl[i][15:0]) begin
        errors++;
        $display("FAIL %s r%0d got %h expected %h", tag, i, tap[i], mdl[i][15:0]);
      end
    end
  endtask

  // One clock: inputs already driven; model follows the edge; sample 1ns after it.
  task automatic step(input string tag);
    logic [63:0] nb;
    nb = ref_bus();
    @(posedge clock);
    if (!reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
    end else if (write && DA != 5'd31) begin
      mdl[DA] = nb;
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic c, bs, wr, eb, ea, input logic [4:0] fs,
                       input logic [63:0] k, input logic [4:0] aa, ba, da);
    cin = c; Bselect = bs; write = wr; EN_B = eb; EN_ALU = ea;
    FS = fs; K = k; AA = aa; BA = ba; DA = da;
  endtask

  task automatic add_vec(input logic c, bs, wr, eb, ea, input logic [4:0] fs,
                         input logic [63:0] k, input logic [4:0] aa, ba, da,
                         input int chk, input logic [15:0] exp);
    vec_t v;
    v.cin = c; v.bsel = bs; v.wr = wr; v.en_b = eb; v.en_alu = ea;
    v.fs = fs; v.k = k; v.aa = aa; v.ba = ba; v.da = da; v.chk = chk; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    //        cin bs wr eb ea  FS        K                       AA  BA  DA  chk exp
    add_vec(0, 1, 1, 1, 0, 5'b00000, 64'd5,                  0,  0,  2,  2, 16'h0005);
    add_vec(0, 1, 1, 1, 0, 5'b00000, 64'd10,                 0,  0,  3,  3, 16'h000A);
    add_vec(0, 1, 1, 0, 1, 5'b01000, 64'd8,                  7,  0,  8,  8, 16'h0008);
    add_vec(0, 1, 1, 0, 1, 5'b01001, 64'd9,                  8,  0,  9,  9, 16'h0000);
    add_vec(0, 0, 1, 0, 1, 5'b00100, 64'd0,                  2,  3,  4,  4, 16'h000F);
    add_vec(0, 0, 1, 0, 1, 5'b01100, 64'd0,                  2,  3,  5,  5, 16'h000F);
    add_vec(0, 0, 1, 0, 1, 5'b00000, 64'd0,                  2,  3,  5,  5, 16'h0000);
    add_vec(0, 1, 1, 1, 0, 5'b00000, 64'h1234,               0,  0,  6,  6, 16'h1234);
    add_vec(0, 0, 1, 1, 0, 5'b00000, 64'd0,                  0,  6,  7,  7, 16'h1234);
    add_vec(0, 1, 1, 1, 0, 5'b00000, 64'd1,                  0,  0,  1,  1, 16'h0001);
    add_vec(0, 1, 1, 0, 1, 5'b10000, 64'd4,                  1,  0, 11, 11, 16'h0010);
    add_vec(0, 1, 1, 1, 0, 5'b00000, 64'h100,                0,  0, 12, 12, 16'h0100);
    add_vec(0, 1, 1, 0, 1, 5'b10100, 64'd4,                 12,  0, 13, 13, 16'h0010);
    add_vec(1, 0, 1, 0, 1, 5'b01010, 64'd0,                  4,  3, 14, 14, 16'h0005);
    add_vec(0, 1, 1, 1, 1, 5'b01000, 64'd1,                  4,  0, 15, 15, 16'h0010);
    add_vec(0, 1, 1, 0, 1, 5'b10011, 64'd8,                  1,  0, 16, 16, 16'h0100);
    add_vec(0, 1, 1, 1, 0, 5'b00000, 64'hABCD_0000_0000_0000, 0, 0, 17, 17, 16'h0000);
    add_vec(0, 1, 1, 0, 1, 5'b10100, 64'd48,                17,  0, 18, 18, 16'hABCD);
    add_vec(0, 1, 1, 0, 1, 5'b11000, 64'd3,                  4,  0,  4,  4, 16'h0000);
    add_vec(0, 1, 1, 1, 0, 5'b00000, 64'hFFFF,               0,  0, 31, 31, 16'h0000);
    add_vec(0, 1, 1, 0, 0, 5'b01000, 64'h7777,               3,  0,  2,  2, 16'h0000);
    add_vec(0, 1, 0, 1, 0, 5'b00000, 64'hBEEF,               0,  0,  3,  3, 16'h000A);

    for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
    reset = 1'b1;
    drive(0, 1, 1, 1, 0, 5'b0, 64'hDEAD, 0, 0, 0);

    // Arbitrary pre-reset writes, then a reset edge that also has write asserted.
    @(posedge clock); #1;
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 1, 1, 0, 5'b0, 64'(32'hA5A5_0000 + i), 0, 0, 5'(i * 5));
      @(posedge clock); #1;
    end
    reset = 1'b0;
    drive(0, 1, 1, 1, 0, 5'b0, 64'hCAFE, 0, 0, 10);
    step("reset");
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].cin, vecs[i].bsel, vecs[i].wr, vecs[i].en_b, vecs[i].en_alu,
            vecs[i].fs, vecs[i].k, vecs[i].aa, vecs[i].ba, vecs[i].da);
      step($sformatf("vec%0d", i));
      checks++;
      if (tap[vecs[i].chk] !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d_const r%0d got %h expected %h",
                 i, vecs[i].chk, tap[vecs[i].chk], vecs[i].exp);
      end
    end

    // Mid-sequence reset with a write pending: everything must clear.
    reset = 1'b0;
    drive(0, 1, 1, 1, 0, 5'b0, 64'h5555, 0, 0, 6);
    step("midreset");
    checks++;
    if (r6 !== 16'h0000 || r2 !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_const r6 got %h r2 got %h expected 0000", r6, r2);
    end
    reset = 1'b1;

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) != 0);
      drive(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
            1'($urandom), 5'($urandom), {$urandom, $urandom},
            5'($urandom), 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) K = 64'($urandom_range(0, 63));
      step($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
